// File: rtl/scan_mux.sv
// scan_mux: registered channel mux with manual select and masked auto-scan; optional out_par when SCAN_MUX_PARITY_EN is defined
module scan_mux #(
  parameter int WIDTH = 8,
  parameter int CH = 16,
  parameter int SELW = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH*WIDTH-1:0] in,
  input  logic [SELW-1:0]     sel,
  input  logic                mode,
  input  logic [CH-1:0]       mask,
  input  logic                run,
  input  logic                ready,
  output logic [WIDTH-1:0]    out,
  output logic [SELW-1:0]     out_ch,
  output logic                valid,
  output logic                err,
`ifdef SCAN_MUX_PARITY_EN
  output logic                out_par,
`endif
  output logic                scan_done
);
  logic [SELW-1:0] ptr, cap, nptr, ch;
  logic [WIDTH-1:0] data;
  logic ld, bad, wrap;
  function automatic logic [SELW-1:0] next_en(input int start, input logic [CH-1:0] m);
    logic [CH-1:0] r;
    next_en = '0;
    for (int i = CH - 1; i >= 0; i--) begin
      r = m >> ((start + i) % CH);
      if (r[0]) next_en = SELW'((start + i) % CH);
    end
  endfunction
  // channel choice, load condition and captured data
  always_comb begin
    cap = next_en(int'(ptr), mask);
    nptr = next_en(int'(cap) + 1, mask);
    wrap = nptr <= cap;
    ch = mode ? cap : sel;
    bad = !mode && int'(sel) >= CH;
    ld = run && (!valid || ready) && (!mode || |mask);
    data = bad ? '0 : WIDTH'(in >> (int'(ch) * WIDTH));
  end
  // sample register, handshake and pulse outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      out <= '0;
      out_ch <= '0;
      valid <= 1'b0;
      err <= 1'b0;
      scan_done <= 1'b0;
      ptr <= '0;
    end else begin
      if (ld) begin
        out <= data;
        out_ch <= ch;
        if (mode) ptr <= nptr;
      end
      valid <= ld || (valid && !ready);
      err <= ld && bad;
      scan_done <= ld && mode && wrap;
    end
  end
`ifdef SCAN_MUX_PARITY_EN
  // parity bit registered alongside out
  always_ff @(posedge clk) begin
    if (rst) out_par <= 1'b0;
    else if (ld) out_par <= ^data;
  end
`endif
endmodule

// File: tb/tb_scan_mux.sv
// tb_scan_mux: directed checks of scan_mux manual, auto-scan, handshake and reset behaviour
module tb_scan_mux;
  localparam int WIDTH = 4, CH = 12, SELW = 4;
  logic clk = 0, rst = 1, mode = 0, run = 0, ready = 0;
  logic [CH*WIDTH-1:0] in = 48'h456789ABCDEF;
  logic [SELW-1:0] sel = '0;
  logic [CH-1:0] mask = '0;
  logic [WIDTH-1:0] out;
  logic [SELW-1:0] out_ch;
  logic valid, err, scan_done;
`ifdef SCAN_MUX_PARITY_EN
  logic out_par;
`endif
  int checks = 0, errors = 0;
  scan_mux #(.WIDTH(WIDTH), .CH(CH), .SELW(SELW)) dut (
    .clk(clk), .rst(rst), .in(in), .sel(sel), .mode(mode), .mask(mask),
    .run(run), .ready(ready), .out(out), .out_ch(out_ch), .valid(valid),
    .err(err),
`ifdef SCAN_MUX_PARITY_EN
    .out_par(out_par),
`endif
    .scan_done(scan_done)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_s(input string tag, input logic [3:0] o, input logic [3:0] c, input logic v, input logic sd);
    chk({tag, "_out"}, 32'(out), 32'(o));
    chk({tag, "_ch"}, 32'(out_ch), 32'(c));
    chk({tag, "_valid"}, 32'(valid), 32'(v));
    chk({tag, "_sd"}, 32'(scan_done), 32'(sd));
  endtask
  initial begin
    step();
    chk_s("reset", 4'h0, 4'd0, 1'b0, 1'b0);
    chk("reset_err", 32'(err), 0);
    rst = 0;
    step();
    chk("idle_valid", 32'(valid), 0);
    mode = 0; ready = 1; run = 1;
    sel = 0; step(); chk_s("m_sel0", 4'hF, 4'd0, 1'b1, 1'b0); chk("m_sel0_err", 32'(err), 0);
    sel = 5; step(); chk_s("m_sel5", 4'hA, 4'd5, 1'b1, 1'b0);
    sel = 11; step(); chk_s("m_sel11", 4'h4, 4'd11, 1'b1, 1'b0); chk("m_sel11_err", 32'(err), 0);
    sel = 12; step(); chk_s("m_sel12", 4'h0, 4'd12, 1'b1, 1'b0); chk("m_sel12_err", 32'(err), 1);
    sel = 3; step(); chk_s("m_sel3", 4'hC, 4'd3, 1'b1, 1'b0); chk("m_sel3_err", 32'(err), 0);
    sel = 14; step(); chk_s("m_sel14", 4'h0, 4'd14, 1'b1, 1'b0); chk("m_sel14_err", 32'(err), 1);
    ready = 0; sel = 2;
    step(); chk_s("hold1", 4'h0, 4'd14, 1'b1, 1'b0); chk("hold1_err", 32'(err), 0);
    step(); chk_s("hold2", 4'h0, 4'd14, 1'b1, 1'b0);
    ready = 1; run = 0;
    step(); chk_s("drain", 4'h0, 4'd14, 1'b0, 1'b0);
    mode = 1; run = 1; mask = 12'hFFF;
    step(); chk_s("a_full0", 4'hF, 4'd0, 1'b1, 1'b0);
    step(); chk_s("a_full1", 4'hE, 4'd1, 1'b1, 1'b0);
    mask = 12'h801;
    step(); chk_s("a_skip11", 4'h4, 4'd11, 1'b1, 1'b1);
    step(); chk_s("a_wrap0", 4'hF, 4'd0, 1'b1, 1'b0);
    step(); chk_s("a_again11", 4'h4, 4'd11, 1'b1, 1'b1);
    mask = 12'h005;
    step(); chk_s("a_m5_0", 4'hF, 4'd0, 1'b1, 1'b0);
    step(); chk_s("a_m5_2", 4'hD, 4'd2, 1'b1, 1'b1);
    step(); chk_s("a_m5_0b", 4'hF, 4'd0, 1'b1, 1'b0);
    mask = 12'h010;
    step(); chk_s("a_one_a", 4'hB, 4'd4, 1'b1, 1'b1);
    step(); chk_s("a_one_b", 4'hB, 4'd4, 1'b1, 1'b1);
    mask = 12'h000;
    step(); chk_s("a_none", 4'hB, 4'd4, 1'b0, 1'b0);
    mode = 0; sel = 1;
    step(); chk_s("sw_man", 4'hE, 4'd1, 1'b1, 1'b0);
`ifdef SCAN_MUX_PARITY_EN
    chk("parity_e", 32'(out_par), 1);
`endif
    mode = 1; mask = 12'hFFF;
    step(); chk_s("resume4", 4'hB, 4'd4, 1'b1, 1'b0);
    step(); chk_s("resume5", 4'hA, 4'd5, 1'b1, 1'b0);
    ready = 0;
    for (int i = 0; i < 3; i++) begin
      step(); chk_s("a_hold", 4'hA, 4'd5, 1'b1, 1'b0);
    end
    ready = 1;
    step(); chk_s("a_after_hold", 4'h9, 4'd6, 1'b1, 1'b0);
    ready = 0;
    step(); chk_s("pend", 4'h9, 4'd6, 1'b1, 1'b0);
    rst = 1;
    step(); chk_s("rst_pend", 4'h0, 4'd0, 1'b0, 1'b0);
    rst = 0; ready = 1;
    step(); chk_s("post_rst", 4'hF, 4'd0, 1'b1, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
